// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the SPI slave register bank.
//   state_t    : frame FSM states (HDR, DATA, SKIP)
//   RW_WRITE   : value of the header R/W bit that selects a write
//   H, DEPTH   : header length and register count for the default geometry
//   CNT_W      : bit-counter width for the default geometry
//   cnt_width(): bit-counter width for any geometry
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        SKIP = 2'd2
    } state_t;

    localparam logic RW_WRITE = 1'b1;

    localparam int H     = 2 + 3 + 3;
    localparam int DEPTH = 2 ** 3;

    // The counter must hold both the header index and the data-bit index.
    function automatic int cnt_width(input int hdr_len, input int data_w);
        int m;
        m = (hdr_len > data_w) ? hdr_len : data_w;
        return $clog2(m + 1);
    endfunction

    localparam int CNT_W = cnt_width(H, 8);

endpackage

// File: rtl/spi_regbank_rf.sv
// Register array for the SPI slave: DEPTH x DATA_W words.
// Asynchronous reset to RESET_VAL, one synchronous write port, two asynchronous read ports.
//   clk, rst         : clock, active-low async reset
//   we, waddr, wdata : write port
//   raddr_a, rdata_a : read port used to load the serial shift register
//   raddr_b, rdata_b : read port used by the side-band debug peek
module spi_regbank_rf #(
    parameter int                 DATA_W     = 8,
    parameter int                 REG_ADDR_W = 3,
    parameter logic [DATA_W-1:0]  RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0]     rdata_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0]     rdata_b
);

    localparam int NREG = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/spi_slave_regbank.sv
// SPI slave with an internal register bank, clocked directly on sclk (all state on posedge).
// Frame, MSB-first: R/W bit, device address, reserved bit, register address, then data words
// repeated while cs is high, with burst auto-increment wrapping at the top of the bank.
// Optional build macro: SPI_REGBANK_ECHO_EN -- during write data phases miso is driven with
// the old word being overwritten, with the same timing as a read.
//   sclk      : SPI clock             rst       : async reset, active-low
//   cs        : chip select, active-high
//   mosi      : serial in             miso      : serial out, 'z when miso_oe=0
//   miso_oe   : miso drive enable     wr_evt    : one-cycle pulse per committed word
//   wr_addr   : address of last committed write
//   frame_err : sticky, frame ended mid-header or mid-word
//   dbg_addr  : peek address          dbg_data  : combinational register[dbg_addr]
//
// state | meaning
// HDR   | collecting header bits; counter = header bit index
// DATA  | device matched; counter = bit index within the current data word
// SKIP  | device mismatch; ignore mosi until cs drops
module spi_slave_regbank
    import spi_regbank_pkg::*;
#(
    parameter int                     DEV_ADDR_W = 3,
    parameter logic [DEV_ADDR_W-1:0]  DEV_ADDR   = 3'b111,
    parameter int                     REG_ADDR_W = 3,
    parameter int                     DATA_W     = 8,
    parameter logic [DATA_W-1:0]      RESET_VAL  = 8'h00
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic                  wr_evt,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic                  frame_err,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int HDR_LEN   = 2 + DEV_ADDR_W + REG_ADDR_W;
    localparam int CNT_WIDTH = cnt_width(HDR_LEN, DATA_W);
    localparam int RSV_POS   = 1 + DEV_ADDR_W;

`ifdef SPI_REGBANK_ECHO_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif

    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [HDR_LEN-3:0]     hdr;       // header minus reserved bit minus the bit being sampled
    logic [HDR_LEN-2:0]     hdr_full;
    logic                   rw_q;
    logic [REG_ADDR_W-1:0]  addr;
    logic [DATA_W-2:0]      sh;
    logic [DATA_W-1:0]      sh_cat;
    logic                   miso_q;

    logic                   hdr_last;
    logic                   word_last;
    logic                   dev_match;
    logic [REG_ADDR_W-1:0]  hdr_reg;
    logic [REG_ADDR_W-1:0]  rd_addr;
    logic [DATA_W-1:0]      rd_data;
    logic                   rf_we;

    // The reserved bit is never stored, so hdr_full = {rw, dev, reg} once the last bit arrives.
    assign hdr_full  = {hdr, mosi};
    assign hdr_reg   = hdr_full[REG_ADDR_W-1:0];
    assign dev_match = (hdr_full[HDR_LEN-3 -: DEV_ADDR_W] == DEV_ADDR);
    assign hdr_last  = (cnt == CNT_WIDTH'(HDR_LEN - 1));
    assign word_last = (cnt == CNT_WIDTH'(DATA_W - 1));

    // One shift register serves both directions: the old word leaves at the top while the
    // incoming word enters at the bottom, so sh_cat holds the full new word on the last bit.
    assign sh_cat = {sh, mosi};

    // Header decode loads from the register field; inside DATA the next word is prefetched.
    assign rd_addr = (state == DATA) ? addr + 1'b1 : hdr_reg;
    assign rf_we   = cs && (state == DATA) && (rw_q == RW_WRITE) && word_last;

    spi_regbank_rf #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .RESET_VAL  (RESET_VAL)
    ) u_rf (
        .clk     (sclk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (addr),
        .wdata   (sh_cat),
        .raddr_a (rd_addr),
        .rdata_a (rd_data),
        .raddr_b (dbg_addr),
        .rdata_b (dbg_data)
    );

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state <= HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!cs) begin
            state_nxt = HDR;
        end else begin
            case (state)
                HDR:     if (hdr_last) state_nxt = dev_match ? DATA : SKIP;
                DATA:    state_nxt = DATA;
                SKIP:    state_nxt = SKIP;
                default: state_nxt = HDR;
            endcase
        end
    end

    always_comb begin
        miso_oe = (state == DATA) && ((rw_q != RW_WRITE) || ECHO_EN);
        miso    = miso_oe ? miso_q : 1'bz;
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            hdr       <= '0;
            rw_q      <= 1'b0;
            addr      <= '0;
            sh        <= '0;
            miso_q    <= 1'b0;
            wr_evt    <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_evt <= 1'b0;
            if (!cs) begin
                cnt <= '0;
                // SKIP never advances the counter, so only real partial frames flag here.
                if (state != SKIP && cnt != '0) begin
                    frame_err <= 1'b1;
                end
            end else begin
                case (state)
                    HDR: begin
                        if (hdr_last) begin
                            cnt <= '0;
                            if (dev_match) begin
                                rw_q   <= hdr_full[HDR_LEN-2];
                                addr   <= hdr_reg;
                                sh     <= rd_data[DATA_W-2:0];
                                miso_q <= rd_data[DATA_W-1];
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (cnt != CNT_WIDTH'(RSV_POS)) begin
                                hdr <= hdr_full[HDR_LEN-3:0];
                            end
                        end
                    end
                    DATA: begin
                        if (word_last) begin
                            cnt    <= '0;
                            addr   <= addr + 1'b1;
                            sh     <= rd_data[DATA_W-2:0];
                            miso_q <= rd_data[DATA_W-1];
                            if (rw_q == RW_WRITE) begin
                                wr_evt  <= 1'b1;
                                wr_addr <= addr;
                            end
                        end else begin
                            cnt    <= cnt + 1'b1;
                            miso_q <= sh_cat[DATA_W-1];
                            sh     <= sh_cat[DATA_W-2:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regbank.sv
module tb_spi_slave_regbank;

`ifdef SPI_REGBANK_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic       sclk = 1'b0;
    logic       rst;
    logic       cs;
    logic       mosi;
    wire        miso;
    logic       miso_oe;
    logic       wr_evt;
    logic [2:0] wr_addr;
    logic       frame_err;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    spi_slave_regbank #(
        .DEV_ADDR_W (3),
        .DEV_ADDR   (3'b111),
        .REG_ADDR_W (3),
        .DATA_W     (8),
        .RESET_VAL  (8'h00)
    ) dut (
        .sclk      (sclk),
        .rst       (rst),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .wr_evt    (wr_evt),
        .wr_addr   (wr_addr),
        .frame_err (frame_err),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 sclk = ~sclk;

    int checks   = 0;
    int failures = 0;

    // Reference model: register contents and expected outputs after the next posedge.
    logic [7:0] regs [8];
    logic       exp_oe, exp_miso, exp_wr_evt, exp_ferr;
    logic [2:0] exp_wr_addr;
    bit         chk_en = 1'b0;

    logic [7:0] tx_words [16];
    logic       rx_q [$];
    int         evt_cnt;
    int         evt_at;
    bit         oe_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 8; a++) regs[a] = 8'h00;
        exp_oe      = 1'b0;
        exp_miso    = 1'b0;
        exp_wr_evt  = 1'b0;
        exp_ferr    = 1'b0;
        exp_wr_addr = 3'd0;
    endtask

    always begin
        @(posedge sclk);
        #1;
        if (chk_en) begin
            chk("miso_oe", {31'd0, miso_oe}, {31'd0, exp_oe});
            if (exp_oe) chk("miso", {31'd0, miso}, {31'd0, exp_miso});
            chk("wr_evt", {31'd0, wr_evt}, {31'd0, exp_wr_evt});
            chk("wr_addr", {29'd0, wr_addr}, {29'd0, exp_wr_addr});
            chk("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
            chk("dbg_data", {24'd0, dbg_data}, {24'd0, regs[dbg_addr]});
        end
    end

    function automatic logic [7:0] rx_byte();
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < 8 && k < rx_q.size(); k++) v = {v[6:0], rx_q[k]};
        return v;
    endfunction

    task automatic mid_reset();
        chk_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_wr_evt", {31'd0, wr_evt}, 32'd0);
        model_reset();
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a);
            #1;
            chk("rst_reg", {24'd0, dbg_data}, 32'h00);
        end
        @(negedge sclk);
        cs = 1'b0;
        @(negedge sclk);
        rst    = 1'b1;
        chk_en = 1'b1;
    endtask

    // Drive one frame of nbits with the model tracking; rst_at >= 0 pulls reset at that bit.
    task automatic frame(input logic [7:0] hdr, input int nbits, input int rst_at);
        logic       rw, match, b;
        logic [2:0] ra;
        logic [7:0] cur;
        int         j, w;
        rw    = hdr[7];
        match = (hdr[6:4] == 3'b111);
        ra    = hdr[2:0];
        cur   = 8'h00;
        rx_q.delete();
        evt_cnt = 0;
        evt_at  = -1;
        oe_seen = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge sclk);
            b        = (i < 8) ? hdr[7-i] : tx_words[(i-8)/8][7-((i-8)%8)];
            cs       = 1'b1;
            mosi     = b;
            dbg_addr = 3'($urandom);
            exp_wr_evt = 1'b0;
            if (match && rw && i >= 8 && (i-8)%8 == 7) begin
                w = (i-8)/8;
                regs[3'(ra + w)] = tx_words[w];
                exp_wr_addr = 3'(ra + w);
                exp_wr_evt  = 1'b1;
            end
            if (match && i >= 7) begin
                j = i - 7;
                if (j%8 == 0) cur = regs[3'(ra + j/8)];
                exp_miso = cur[7 - j%8];
                exp_oe   = !rw || ECHO;
            end else begin
                exp_oe = 1'b0;
            end
            if (i == rst_at) begin
                mid_reset();
                return;
            end
            @(posedge sclk);
            #2;
            if (miso_oe) begin
                oe_seen = 1'b1;
                if (i >= 7) rx_q.push_back(miso);
            end
            if (wr_evt) begin
                evt_cnt++;
                if (evt_at < 0) evt_at = i;
            end
        end
        @(negedge sclk);
        cs         = 1'b0;
        mosi       = 1'($urandom);
        exp_oe     = 1'b0;
        exp_wr_evt = 1'b0;
        if (nbits > 0 && nbits < 8) exp_ferr = 1'b1;
        else if (nbits >= 8 && match && (nbits-8)%8 != 0) exp_ferr = 1'b1;
        @(posedge sclk);
        #2;
    endtask

    task automatic peek(input string name, input logic [2:0] a, input logic [7:0] expv);
        dbg_addr = a;
        #1;
        chk(name, {24'd0, dbg_data}, {24'd0, expv});
    endtask

    initial begin
        logic [7:0] h;
        int         n;
        rst      = 1'b0;
        cs       = 1'b0;
        mosi     = 1'b0;
        dbg_addr = 3'd0;
        for (int k = 0; k < 16; k++) tx_words[k] = 8'h00;
        model_reset();
        #1;
        chk("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("reset_wr_evt", {31'd0, wr_evt}, 32'd0);
        chk("reset_wr_addr", {29'd0, wr_addr}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a);
            #1;
            chk("reset_reg", {24'd0, dbg_data}, 32'h00);
        end
        @(negedge sclk);
        rst    = 1'b1;
        chk_en = 1'b1;

        // 1: single write A5 to register 2
        tx_words[0] = 8'hA5;
        frame(8'hF2, 16, -1);
        chk("t1_evt_cnt", evt_cnt, 1);
        chk("t1_evt_bit", evt_at, 15);
        chk("t1_wr_addr", {29'd0, wr_addr}, 32'd2);
        peek("t1_reg2", 3'd2, 8'hA5);

        // 2: read register 2 twice
        frame(8'h72, 16, -1);
        chk("t2_rx_len", rx_q.size(), 9);
        chk("t2_rx", {24'd0, rx_byte()}, 32'hA5);
        chk("t2_evt_cnt", evt_cnt, 0);
        frame(8'h72, 16, -1);
        chk("t2_reread", {24'd0, rx_byte()}, 32'hA5);

        // 3: burst write across the wrap
        tx_words[0] = 8'h11;
        tx_words[1] = 8'h22;
        frame(8'hF7, 24, -1);
        chk("t3_evt_cnt", evt_cnt, 2);
        peek("t3_reg7", 3'd7, 8'h11);
        peek("t3_reg0", 3'd0, 8'h22);

        // 4: other device address
        tx_words[0] = 8'hFF;
        tx_words[1] = 8'h00;
        frame(8'hB2, 24, -1);
        chk("t4_evt_cnt", evt_cnt, 0);
        chk("t4_oe_seen", {31'd0, oe_seen}, 32'd0);
        chk("t4_frame_err", {31'd0, frame_err}, 32'd0);
        peek("t4_reg2", 3'd2, 8'hA5);

        // 5: aborted write, then a clean frame
        tx_words[0] = 8'h3C;
        frame(8'hF2, 12, -1);
        chk("t5_frame_err", {31'd0, frame_err}, 32'd1);
        chk("t5_evt_cnt", evt_cnt, 0);
        peek("t5_reg2", 3'd2, 8'hA5);
        tx_words[0] = 8'h5A;
        frame(8'hF3, 16, -1);
        chk("t5_evt_after", evt_cnt, 1);
        peek("t5_reg3", 3'd3, 8'h5A);

        // 6: reset in the middle of a read, then echo behaviour
        frame(8'h72, 12, 10);
        chk("t6_frame_err", {31'd0, frame_err}, 32'd0);
        tx_words[0] = 8'h77;
        frame(8'hF4, 16, -1);
        tx_words[0] = 8'h88;
        frame(8'hF4, 16, -1);
`ifdef SPI_REGBANK_ECHO_EN
        chk("t6_echo_old", {24'd0, rx_byte()}, 32'h77);
`else
        chk("t6_no_echo", {31'd0, oe_seen}, 32'd0);
`endif
        peek("t6_reg4", 3'd4, 8'h88);

        // Randomised frames against the model
        for (int f = 0; f < 60; f++) begin
            h = 8'($urandom);
            if ($urandom_range(0, 2) != 0) h[6:4] = 3'b111;
            if ($urandom_range(0, 7) == 0) n = $urandom_range(1, 20);
            else n = 8 + 8 * $urandom_range(0, 3);
            for (int k = 0; k < 16; k++) tx_words[k] = 8'($urandom);
            frame(h, n, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
